// File: rtl/gambit_biu_pkg.sv
`default_nettype none
// ==========================================================================
// gambit_biu_pkg : shared types for the BIU arbiter (states, CTI, responses)
// Revision 1.0
// ==========================================================================
package gambit_biu_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_OWN_IC = 3'd1,
        ST_OWN_DC = 3'd2,
        ST_TURN   = 3'd3,
        ST_ABORT  = 3'd4
    } arb_state_t;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b001;
    localparam logic [2:0] CTI_EOB     = 3'b111;

    typedef struct packed {
        logic ack;
        logic err;
        logic tlbmiss;
        logic exv;
        logic bok;
    } biu_resp_t;

endpackage
`default_nettype wire

// File: rtl/gambit_biu_timeout.sv
`default_nettype none
// ==========================================================================
// gambit_biu_timeout : 8-bit saturating no-response watchdog
// Revision 1.0
// ==========================================================================
module gambit_biu_timeout #(
    parameter int LIMIT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_reached
);

    logic [7:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en && (r_cnt != 8'hFF)) begin
            r_cnt <= r_cnt + 8'd1;
        end
    end

    // Fires in the cycle whose increment would bring the count to LIMIT.
    assign o_reached = i_en && (r_cnt >= 8'(LIMIT - 1));

endmodule
`default_nettype wire

// File: rtl/gambit_biu_arbiter.sv
`default_nettype none
// ==========================================================================
// gambit_biu_arbiter : IC/DC bus arbiter with turnaround and response timeout
// Revision 1.0
// ==========================================================================
module gambit_biu_arbiter
    import gambit_biu_pkg::*;
#(
    parameter int AMSB    = 63,
    parameter int TIMEOUT = 255
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            ic_cyc_i,
    input  logic            ic_stb_i,
    input  logic [2:0]      ic_cti_i,
    input  logic [1:0]      ic_bte_i,
    input  logic [15:0]     ic_sel_i,
    input  logic [AMSB:0]   ic_adr_i,
    input  logic            dc_cyc_i,
    input  logic            dc_stb_i,
    input  logic            dc_we_i,
    input  logic [15:0]     dc_sel_i,
    input  logic [AMSB:0]   dc_adr_i,
    input  logic [127:0]    dc_dat_i,
    output logic            ic_ack_o,
    output logic            ic_err_o,
    output logic            ic_tlbmiss_o,
    output logic            ic_exv_o,
    output logic            ic_bok_o,
    output logic            dc_ack_o,
    output logic            dc_err_o,
    output logic            dc_tlbmiss_o,
    output logic            dc_exv_o,
    output logic            dc_bok_o,
    output logic [127:0]    dat_o,
    output logic            cyc_o,
    output logic            stb_o,
    output logic            we_o,
    output logic [2:0]      cti_o,
    output logic [1:0]      bte_o,
    output logic [15:0]     sel_o,
    output logic [AMSB:0]   adr_o,
    output logic [127:0]    bus_dat_o,
    input  logic            ack_i,
    input  logic            err_i,
    input  logic            tlbmiss_i,
    input  logic            exv_i,
    input  logic            bok_i,
    input  logic [127:0]    bus_dat_i,
    output logic [1:0]      grant_o
);

    arb_state_t r_state, w_next;
    logic       r_last_ic;
    logic       r_arb_seen;

    logic            w_own_ic, w_own_dc, w_owned, w_owner_cyc;
    logic            w_any_resp, w_to_en, w_to_clr, w_reached, w_abort;
    logic            w_raw_cyc, w_raw_stb, w_raw_we;
    logic [2:0]      w_raw_cti;
    logic [1:0]      w_raw_bte;
    logic [15:0]     w_raw_sel;
    logic [AMSB:0]   w_raw_adr;
    logic [127:0]    w_raw_dat;
    biu_resp_t       w_bus_resp, w_ic_resp, w_dc_resp;

    assign w_own_ic    = (r_state == ST_OWN_IC);
    assign w_own_dc    = (r_state == ST_OWN_DC);
    assign w_owned     = w_own_ic || w_own_dc;
    assign w_owner_cyc = r_last_ic ? ic_cyc_i : dc_cyc_i;
    assign w_bus_resp  = '{ack: ack_i, err: err_i, tlbmiss: tlbmiss_i, exv: exv_i, bok: bok_i};
    assign w_any_resp  = ack_i || err_i || tlbmiss_i || exv_i;

    always_comb begin
        w_raw_cyc = 1'b0;
        w_raw_stb = 1'b0;
        w_raw_we  = 1'b0;
        w_raw_cti = CTI_CLASSIC;
        w_raw_bte = 2'b00;
        w_raw_sel = '0;
        w_raw_adr = '0;
        w_raw_dat = '0;
        case (r_state)
            ST_OWN_IC: begin
                w_raw_cyc = ic_cyc_i;
                w_raw_stb = ic_stb_i;
                w_raw_cti = ic_cti_i;
                w_raw_bte = ic_bte_i;
                w_raw_sel = ic_sel_i;
                w_raw_adr = ic_adr_i;
            end
            ST_OWN_DC: begin
                w_raw_cyc = dc_cyc_i;
                w_raw_stb = dc_stb_i;
                w_raw_we  = dc_we_i;
                w_raw_sel = dc_sel_i;
                w_raw_adr = dc_adr_i;
                w_raw_dat = dc_dat_i;
            end
            default: ;
        endcase
    end

    assign w_to_en  = w_owned && w_raw_cyc && w_raw_stb && !w_any_resp;
    assign w_to_clr = (r_state == ST_IDLE) || (r_state == ST_TURN) || w_any_resp;

    gambit_biu_timeout #(
        .LIMIT (TIMEOUT)
    ) u_timeout (
        .clk       (clk_i),
        .rst_n     (rst_i),
        .i_clr     (w_to_clr),
        .i_en      (w_to_en),
        .o_reached (w_reached)
    );

    assign w_abort = w_owned && w_reached;

    assign cyc_o     = w_raw_cyc && !w_abort;
    assign stb_o     = w_raw_stb && !w_abort;
    assign we_o      = w_raw_we  && !w_abort;
    assign cti_o     = w_abort ? CTI_CLASSIC : w_raw_cti;
    assign bte_o     = w_abort ? 2'b00 : w_raw_bte;
    assign sel_o     = w_abort ? '0 : w_raw_sel;
    assign adr_o     = w_abort ? '0 : w_raw_adr;
    assign bus_dat_o = w_abort ? '0 : w_raw_dat;
    assign dat_o     = (w_owned && !w_abort) ? bus_dat_i : '0;
    assign grant_o   = {w_own_dc, w_own_ic};

    // On the abort cycle the owner sees only the synthetic error pulse.
    always_comb begin
        w_ic_resp = '0;
        w_dc_resp = '0;
        if (w_abort) begin
            w_ic_resp.err = w_own_ic;
            w_dc_resp.err = w_own_dc;
        end else begin
            if (w_own_ic) w_ic_resp = w_bus_resp;
            if (w_own_dc) w_dc_resp = w_bus_resp;
        end
    end

    assign ic_ack_o     = w_ic_resp.ack;
    assign ic_err_o     = w_ic_resp.err;
    assign ic_tlbmiss_o = w_ic_resp.tlbmiss;
    assign ic_exv_o     = w_ic_resp.exv;
    assign ic_bok_o     = w_ic_resp.bok;
    assign dc_ack_o     = w_dc_resp.ack;
    assign dc_err_o     = w_dc_resp.err;
    assign dc_tlbmiss_o = w_dc_resp.tlbmiss;
    assign dc_exv_o     = w_dc_resp.exv;
    assign dc_bok_o     = w_dc_resp.bok;

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                // Tie-break favours the master not granted last; DC before any grant.
                if (ic_cyc_i && dc_cyc_i)
                    w_next = (r_last_ic || !r_arb_seen) ? ST_OWN_DC : ST_OWN_IC;
                else if (ic_cyc_i)
                    w_next = ST_OWN_IC;
                else if (dc_cyc_i)
                    w_next = ST_OWN_DC;
            end
            ST_OWN_IC: begin
                if (!ic_cyc_i)      w_next = ST_TURN;
                else if (w_reached) w_next = ST_ABORT;
            end
            ST_OWN_DC: begin
                if (!dc_cyc_i)      w_next = ST_TURN;
                else if (w_reached) w_next = ST_ABORT;
            end
            ST_TURN:  w_next = ST_IDLE;
            ST_ABORT: if (!w_owner_cyc) w_next = ST_TURN;
            default:  w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_last_ic  <= 1'b0;
            r_arb_seen <= 1'b0;
        end else if (r_state == ST_IDLE) begin
            if (w_next == ST_OWN_IC) begin
                r_last_ic  <= 1'b1;
                r_arb_seen <= 1'b1;
            end else if (w_next == ST_OWN_DC) begin
                r_last_ic  <= 1'b0;
                r_arb_seen <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_gambit_biu_arbiter.sv
`default_nettype none
// ==========================================================================
// tb_gambit_biu_arbiter : scoreboard bench with directed and random traffic
// Revision 1.0
// ==========================================================================
module tb_gambit_biu_arbiter;
    import gambit_biu_pkg::*;

    localparam int AMSB = 63;
    localparam int TO   = 4;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b0;
    logic          ic_cyc_i, ic_stb_i, dc_cyc_i, dc_stb_i, dc_we_i;
    logic [2:0]    ic_cti_i;
    logic [1:0]    ic_bte_i;
    logic [15:0]   ic_sel_i, dc_sel_i;
    logic [AMSB:0] ic_adr_i, dc_adr_i;
    logic [127:0]  dc_dat_i, bus_dat_i;
    logic          ack_i, err_i, tlbmiss_i, exv_i, bok_i;
    logic          ic_ack_o, ic_err_o, ic_tlbmiss_o, ic_exv_o, ic_bok_o;
    logic          dc_ack_o, dc_err_o, dc_tlbmiss_o, dc_exv_o, dc_bok_o;
    logic [127:0]  dat_o, bus_dat_o;
    logic          cyc_o, stb_o, we_o;
    logic [2:0]    cti_o;
    logic [1:0]    bte_o, grant_o;
    logic [15:0]   sel_o;
    logic [AMSB:0] adr_o;

    gambit_biu_arbiter #(.AMSB(AMSB), .TIMEOUT(TO)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .ic_cyc_i(ic_cyc_i), .ic_stb_i(ic_stb_i), .ic_cti_i(ic_cti_i), .ic_bte_i(ic_bte_i),
        .ic_sel_i(ic_sel_i), .ic_adr_i(ic_adr_i),
        .dc_cyc_i(dc_cyc_i), .dc_stb_i(dc_stb_i), .dc_we_i(dc_we_i), .dc_sel_i(dc_sel_i),
        .dc_adr_i(dc_adr_i), .dc_dat_i(dc_dat_i),
        .ic_ack_o(ic_ack_o), .ic_err_o(ic_err_o), .ic_tlbmiss_o(ic_tlbmiss_o),
        .ic_exv_o(ic_exv_o), .ic_bok_o(ic_bok_o),
        .dc_ack_o(dc_ack_o), .dc_err_o(dc_err_o), .dc_tlbmiss_o(dc_tlbmiss_o),
        .dc_exv_o(dc_exv_o), .dc_bok_o(dc_bok_o),
        .dat_o(dat_o), .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o), .cti_o(cti_o),
        .bte_o(bte_o), .sel_o(sel_o), .adr_o(adr_o), .bus_dat_o(bus_dat_o),
        .ack_i(ack_i), .err_i(err_i), .tlbmiss_i(tlbmiss_i), .exv_i(exv_i), .bok_i(bok_i),
        .bus_dat_i(bus_dat_i), .grant_o(grant_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [4:0]    ic_r;
        logic [4:0]    dc_r;
        logic [127:0]  dat;
        logic          cyc;
        logic          stb;
        logic          we;
        logic [2:0]    cti;
        logic [1:0]    bte;
        logic [15:0]   sel;
        logic [AMSB:0] adr;
        logic [127:0]  bdat;
        logic [1:0]    grant;
    } obs_t;

    obs_t exp_q[$];
    obs_t mon_e, mon_a;
    int   n_checks = 0;
    int   n_err    = 0;

    // Reference model: who owns the bus (0 none, 1 IC, 2 DC), who was granted last,
    // whether the owner was aborted, whether we are in the dead cycle, and the
    // number of consecutive unanswered strobe cycles.
    int m_owner, m_last, m_cnt;
    bit m_abort, m_turn;
    int ic_left, dc_left;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    function automatic obs_t actual();
        obs_t a;
        a.ic_r  = {ic_ack_o, ic_err_o, ic_tlbmiss_o, ic_exv_o, ic_bok_o};
        a.dc_r  = {dc_ack_o, dc_err_o, dc_tlbmiss_o, dc_exv_o, dc_bok_o};
        a.dat   = dat_o;
        a.cyc   = cyc_o;
        a.stb   = stb_o;
        a.we    = we_o;
        a.cti   = cti_o;
        a.bte   = bte_o;
        a.sel   = sel_o;
        a.adr   = adr_o;
        a.bdat  = bus_dat_o;
        a.grant = grant_o;
        return a;
    endfunction

    function automatic bit any_resp();
        return ack_i || err_i || tlbmiss_i || exv_i;
    endfunction

    function automatic bit owner_cyc();
        return (m_owner == 1) ? ic_cyc_i : dc_cyc_i;
    endfunction

    function automatic bit owner_stb();
        return (m_owner == 1) ? ic_stb_i : dc_stb_i;
    endfunction

    function automatic bit holds_bus();
        return (m_owner != 0) && !m_abort && !m_turn;
    endfunction

    function automatic bit times_out();
        return holds_bus() && owner_cyc() && owner_stb() && !any_resp() && (m_cnt + 1 >= TO);
    endfunction

    function automatic obs_t model_out();
        obs_t e = '0;
        if (holds_bus()) begin
            e.grant = (m_owner == 1) ? 2'b01 : 2'b10;
            if (times_out()) begin
                if (m_owner == 1) e.ic_r = 5'b01000;
                else              e.dc_r = 5'b01000;
            end else begin
                if (m_owner == 1) begin
                    e.cyc = ic_cyc_i; e.stb = ic_stb_i; e.cti = ic_cti_i;
                    e.bte = ic_bte_i; e.sel = ic_sel_i; e.adr = ic_adr_i;
                    e.ic_r = {ack_i, err_i, tlbmiss_i, exv_i, bok_i};
                end else begin
                    e.cyc = dc_cyc_i; e.stb = dc_stb_i; e.we = dc_we_i;
                    e.sel = dc_sel_i; e.adr = dc_adr_i; e.bdat = dc_dat_i;
                    e.dc_r = {ack_i, err_i, tlbmiss_i, exv_i, bok_i};
                end
                e.dat = bus_dat_i;
            end
        end
        return e;
    endfunction

    task automatic model_reset();
        m_owner = 0; m_last = 0; m_cnt = 0; m_abort = 0; m_turn = 0;
    endtask

    // Advance the model across one rising edge using the inputs of the cycle just ended.
    task automatic model_step();
        bit fire;
        fire = times_out();
        if (m_turn) begin
            m_turn = 0; m_owner = 0; m_cnt = 0;
        end else if (m_abort) begin
            if (!owner_cyc()) begin m_abort = 0; m_turn = 1; end
        end else if (m_owner != 0) begin
            if (!owner_cyc())  m_turn = 1;
            else if (fire)     m_abort = 1;
            if (any_resp())    m_cnt = 0;
            else if (owner_cyc() && owner_stb() && m_cnt < 255) m_cnt = m_cnt + 1;
        end else begin
            m_cnt = 0;
            if (ic_cyc_i && dc_cyc_i) m_owner = (m_last == 2) ? 1 : 2;
            else if (ic_cyc_i)        m_owner = 1;
            else if (dc_cyc_i)        m_owner = 2;
            if (m_owner != 0) m_last = m_owner;
        end
    endtask

    always @(negedge clk_i) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            mon_a = actual();
            chk("ic_resp", 128'(mon_a.ic_r),  128'(mon_e.ic_r));
            chk("dc_resp", 128'(mon_a.dc_r),  128'(mon_e.dc_r));
            chk("dat_o",   mon_a.dat,         mon_e.dat);
            chk("bus_ctl", 128'({mon_a.cyc, mon_a.stb, mon_a.we, mon_a.cti, mon_a.bte, mon_a.sel}),
                           128'({mon_e.cyc, mon_e.stb, mon_e.we, mon_e.cti, mon_e.bte, mon_e.sel}));
            chk("adr_o",   128'(mon_a.adr),   128'(mon_e.adr));
            chk("bus_dat", mon_a.bdat,        mon_e.bdat);
            chk("grant",   128'(mon_a.grant), 128'(mon_e.grant));
        end
    end

    task automatic step();
        @(posedge clk_i);
        model_step();
        #1;
    endtask

    task automatic push();
        exp_q.push_back(model_out());
    endtask

    task automatic set_idle();
        ic_cyc_i = 0; ic_stb_i = 0; ic_cti_i = '0; ic_bte_i = '0; ic_sel_i = '0; ic_adr_i = '0;
        dc_cyc_i = 0; dc_stb_i = 0; dc_we_i = 0; dc_sel_i = '0; dc_adr_i = '0; dc_dat_i = '0;
        ack_i = 0; err_i = 0; tlbmiss_i = 0; exv_i = 0; bok_i = 0; bus_dat_i = '0;
        ic_left = 0; dc_left = 0;
    endtask

    task automatic rand_inputs(input int ack_pct);
        if (ic_cyc_i && ic_left == 0)      ic_cyc_i = 0;
        else if (ic_cyc_i)                 ic_left--;
        else if ($urandom % 3 == 0) begin  ic_cyc_i = 1; ic_left = $urandom_range(0, 7); end
        if (dc_cyc_i && dc_left == 0)      dc_cyc_i = 0;
        else if (dc_cyc_i)                 dc_left--;
        else if ($urandom % 3 == 0) begin  dc_cyc_i = 1; dc_left = $urandom_range(0, 7); end
        ic_stb_i  = ic_cyc_i && ($urandom % 4 != 0);
        dc_stb_i  = dc_cyc_i && ($urandom % 4 != 0);
        ic_cti_i  = 3'($urandom);
        ic_bte_i  = 2'($urandom);
        ic_sel_i  = 16'($urandom);
        ic_adr_i  = {$urandom, $urandom};
        dc_we_i   = ($urandom % 2) == 0;
        dc_sel_i  = 16'($urandom);
        dc_adr_i  = {$urandom, $urandom};
        dc_dat_i  = {$urandom, $urandom, $urandom, $urandom};
        ack_i     = ($urandom % 100) < ack_pct;
        err_i     = ($urandom % 20) == 0;
        tlbmiss_i = ($urandom % 20) == 0;
        exv_i     = ($urandom % 20) == 0;
        bok_i     = ($urandom % 2) == 0;
        bus_dat_i = {$urandom, $urandom, $urandom, $urandom};
    endtask

    initial begin
        logic [2:0] burst_cti [4];
        burst_cti[0] = CTI_INCR; burst_cti[1] = CTI_INCR;
        burst_cti[2] = CTI_INCR; burst_cti[3] = CTI_EOB;

        // Reset held with traffic and bus responses present: every output must stay 0.
        set_idle();
        ic_cyc_i = 1; ic_stb_i = 1; dc_cyc_i = 1; dc_stb_i = 1; ack_i = 1;
        bus_dat_i = {4{32'hDEADBEEF}};
        #12;
        chk("reset_outputs", 128'(actual()), 128'(0));
        #10;
        chk("reset_grant", 128'(grant_o), 128'(0));
        chk("reset_cyc", 128'({cyc_o, stb_o}), 128'(0));
        @(posedge clk_i); #1;
        set_idle();
        model_reset();
        #2 rst_i = 1;

        // Simultaneous request: DC first, then IC after the turnaround.
        step(); ic_cyc_i = 1; ic_stb_i = 1; dc_cyc_i = 1; dc_stb_i = 1; push();
        for (int i = 0; i < 3; i++) begin step(); ack_i = 1; dc_we_i = 1; dc_dat_i = 128'(i + 7); push(); end
        step(); dc_cyc_i = 0; dc_stb_i = 0; dc_we_i = 0; ack_i = 0; push();
        for (int i = 0; i < 3; i++) begin step(); push(); end

        // IC 4-beat burst with acks every beat.
        for (int i = 0; i < 4; i++) begin
            step(); ic_cti_i = burst_cti[i]; ic_bte_i = 2'b01; ic_adr_i = 64'(32'h1000 + 16 * i);
            ack_i = 1; bus_dat_i = 128'(i + 100); push();
        end
        step(); set_idle(); push();
        for (int i = 0; i < 3; i++) begin step(); push(); end

        // IC retry sequence with bok=0 while DC waits.
        step(); ic_cyc_i = 1; ic_stb_i = 1; ic_cti_i = CTI_INCR; push();
        for (int i = 0; i < 8; i++) begin
            step(); dc_cyc_i = 1; dc_stb_i = 1; ic_stb_i = (i % 2) == 0;
            ack_i = (i % 2) == 0; bok_i = 0; push();
        end
        step(); ic_cyc_i = 0; ic_stb_i = 0; ack_i = 0; push();
        for (int i = 0; i < 4; i++) begin step(); ack_i = 1; push(); end
        step(); set_idle(); push();
        for (int i = 0; i < 3; i++) begin step(); push(); end

        // IC with no response: abort on the TO-th strobe cycle, held until cyc drops.
        step(); ic_cyc_i = 1; ic_stb_i = 1; ic_sel_i = 16'hFFFF; push();
        for (int i = 0; i < TO + 3; i++) begin step(); push(); end
        step(); ic_cyc_i = 0; ic_stb_i = 0; push();
        for (int i = 0; i < 3; i++) begin step(); push(); end

        // DC write receiving err and tlbmiss, then long wait that must not time out early.
        step(); dc_cyc_i = 1; dc_stb_i = 1; dc_we_i = 1; dc_dat_i = {4{32'hA5A5_5A5A}}; push();
        step(); push();
        step(); err_i = 1; tlbmiss_i = 1; push();
        step(); err_i = 0; tlbmiss_i = 0; push();
        for (int i = 0; i < TO; i++) begin step(); push(); end
        step(); set_idle(); push();
        for (int i = 0; i < 3; i++) begin step(); push(); end

        // Randomised traffic with varying response density.
        for (int ph = 0; ph < 4; ph++) begin
            for (int i = 0; i < 800; i++) begin
                step(); rand_inputs((ph == 0) ? 80 : (ph == 1) ? 40 : (ph == 2) ? 10 : 0); push();
            end
        end
        step(); set_idle(); push();
        for (int i = 0; i < 4; i++) begin step(); push(); end

        // Asynchronous reset in the middle of an IC burst.
        step(); ic_cyc_i = 1; ic_stb_i = 1; ic_cti_i = CTI_INCR; push();
        for (int i = 0; i < 2; i++) begin step(); ack_i = 1; bus_dat_i = 128'(i + 1); push(); end
        #2;
        rst_i = 0;
        exp_q.delete();
        #1;
        chk("async_reset_ctl", 128'({cyc_o, stb_o, grant_o}), 128'(0));
        chk("async_reset_outputs", 128'(actual()), 128'(0));
        @(posedge clk_i); #1;
        set_idle();
        model_reset();
        #2 rst_i = 1;
        step(); dc_cyc_i = 1; dc_stb_i = 1; push();
        step(); ack_i = 1; push();
        step(); dc_cyc_i = 0; dc_stb_i = 0; ack_i = 0; push();
        for (int i = 0; i < 4; i++) begin step(); push(); end
        @(negedge clk_i);
        #1;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
`default_nettype wire
